// File: rtl/spi_byte_phy_pkg.sv
// Shared types and constants for the byte-level SPI master PHY.
package spi_byte_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ASSERT   = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_GAP      = 3'd3,
        ST_DEASSERT = 3'd4
    } spi_state_e;

    localparam int unsigned SPI_BYTE_W     = 8;
    localparam int unsigned SPI_HALF_TICKS = 16;

endpackage

// File: rtl/spi_byte_phy_clk_div.sv
// Half-period tick generator: pulses every CLK_DIV enabled cycles, restartable via clr.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = en && (cnt_q == DIV_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_byte_phy.sv
// Byte-level SPI master PHY, mode 0, MSB first; chip select held low across
// chained bytes until a byte tagged last completes or cs_release is pulsed.
module spi_byte_phy
    import spi_byte_phy_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       last,
    input  logic [7:0] din,
    input  logic       cs_release,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy,
    input  logic       sdi,
    output logic       sdo,
    output logic       clk_out,
    output logic       cs
);

    localparam logic [3:0] LAST_HALF = 4'(SPI_HALF_TICKS - 1);

    spi_state_e state_q, state_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;
    logic [SPI_BYTE_W-1:0] rx_q, rx_d;
    logic [SPI_BYTE_W-1:0] dout_q, dout_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic last_q, last_d;
    logic dout_valid_q, dout_valid_d;
    logic busy_q, busy_d;
    logic clk_out_q, clk_out_d;
    logic cs_q, cs_d;
    logic tick;
    logic div_en;
    logic div_clr;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .reset(reset),
        .clr  (div_clr),
        .en   (div_en),
        .tick (tick)
    );

    assign div_en  = (state_q == ST_ASSERT) || (state_q == ST_SHIFT) ||
                     (state_q == ST_DEASSERT);
    assign div_clr = (state_d != state_q);

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        dout_d       = dout_q;
        bit_cnt_d    = bit_cnt_q;
        last_d       = last_q;
        dout_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    tx_d    = din;
                    last_d  = last;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (!clk_out_q) begin
                        rx_d = {rx_q[SPI_BYTE_W-2:0], sdi};
                    end else if (bit_cnt_q != LAST_HALF) begin
                        tx_d = {tx_q[SPI_BYTE_W-2:0], 1'b0};
                    end
                    // Final falling edge: keep bit 0 on sdo and hand the byte up.
                    if (bit_cnt_q == LAST_HALF) begin
                        dout_d       = rx_q;
                        dout_valid_d = 1'b1;
                        state_d      = last_q ? ST_DEASSERT : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (start) begin
                    tx_d      = din;
                    last_d    = last;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end else if (cs_release) begin
                    state_d = ST_DEASSERT;
                end
            end
            ST_DEASSERT: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        clk_out_d = 1'b0;
        if (state_d == ST_SHIFT) begin
            clk_out_d = clk_out_q ^ ((state_q == ST_SHIFT) && tick);
        end
        cs_d   = (state_d == ST_IDLE);
        busy_d = (state_d == ST_ASSERT) || (state_d == ST_SHIFT) ||
                 (state_d == ST_DEASSERT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            dout_q       <= '0;
            bit_cnt_q    <= '0;
            last_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            clk_out_q    <= 1'b0;
            cs_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            dout_q       <= dout_d;
            bit_cnt_q    <= bit_cnt_d;
            last_q       <= last_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            clk_out_q    <= clk_out_d;
            cs_q         <= cs_d;
        end
    end

    assign sdo        = tx_q[SPI_BYTE_W-1];
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    assign clk_out    = clk_out_q;
    assign cs         = cs_q;

endmodule

// File: tb/tb_spi_byte_phy.sv
// Directed bench for spi_byte_phy at CLK_DIV=4 and CLK_DIV=1.
module tb_spi_byte_phy;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       start4, last4, cs_rel4, sdi4, sdo4, clk_out4, cs4, dv4, busy4;
    logic [7:0] din4, dout4;
    logic       loop4, tie4;
    assign sdi4 = loop4 ? sdo4 : tie4;

    logic       start1, last1, cs_rel1, sdi1, sdo1, clk_out1, cs1, dv1, busy1;
    logic [7:0] din1, dout1;
    assign sdi1 = sdo1;

    spi_byte_phy #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .last(last4), .din(din4),
        .cs_release(cs_rel4), .dout(dout4), .dout_valid(dv4), .busy(busy4),
        .sdi(sdi4), .sdo(sdo4), .clk_out(clk_out4), .cs(cs4)
    );

    spi_byte_phy #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .last(last1), .din(din1),
        .cs_release(cs_rel1), .dout(dout1), .dout_valid(dv1), .busy(busy1),
        .sdi(sdi1), .sdo(sdo1), .clk_out(clk_out1), .cs(cs1)
    );

    int checks = 0;
    int errors = 0;

    int cyc;
    int rises[2], first_rise[2], second_rise[2], hi_cnt[2];
    int dv_cnt[2], dv_cyc[2], cs_rise[2], cs_hi[2];
    logic [7:0] dv_data[2];
    logic prev_clk[2], prev_cs[2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_stats();
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            rises[d] = 0; first_rise[d] = 0; second_rise[d] = 0; hi_cnt[d] = 0;
            dv_cnt[d] = 0; dv_cyc[d] = 0; cs_rise[d] = 0; cs_hi[d] = 0;
            dv_data[d] = '0;
            prev_clk[d] = (d == 0) ? clk_out4 : clk_out1;
            prev_cs[d]  = (d == 0) ? cs4 : cs1;
        end
    endtask

    task automatic step();
        logic co, dv, cs;
        logic [7:0] dt;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            co = (d == 0) ? clk_out4 : clk_out1;
            dv = (d == 0) ? dv4 : dv1;
            cs = (d == 0) ? cs4 : cs1;
            dt = (d == 0) ? dout4 : dout1;
            if (co && !prev_clk[d]) begin
                rises[d]++;
                if (first_rise[d] == 0) first_rise[d] = cyc;
                else if (second_rise[d] == 0) second_rise[d] = cyc;
            end
            if (co) hi_cnt[d]++;
            if (dv) begin
                dv_cnt[d]++;
                if (dv_cyc[d] == 0) begin
                    dv_cyc[d]  = cyc;
                    dv_data[d] = dt;
                end
            end
            if (cs && !prev_cs[d] && cs_rise[d] == 0) cs_rise[d] = cyc;
            if (cs) cs_hi[d]++;
            prev_clk[d] = co;
            prev_cs[d]  = cs;
        end
    endtask

    task automatic wait_dv(input int d, input int budget);
        int base;
        int n;
        base = dv_cnt[d];
        n = 0;
        while (dv_cnt[d] == base && n < budget) begin
            step();
            n++;
        end
        if (dv_cnt[d] == base) chk("dv_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        start4 = 0; last4 = 0; cs_rel4 = 0; din4 = '0; loop4 = 1; tie4 = 0;
        start1 = 0; last1 = 0; cs_rel1 = 0; din1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", cs4, 1);
        chk("rst_clk_out", clk_out4, 0);
        chk("rst_sdo", sdo4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_dout", dout4, 0);
        chk("rst_dv", dv4, 0);
        reset = 1'b1;
        step();

        // 1: single byte from IDLE, loopback
        din4 = 8'hA5; last4 = 1; start4 = 1;
        clr_stats();
        step();
        start4 = 0;
        chk("t1_cs_low", cs4, 0);
        chk("t1_busy", busy4, 1);
        chk("t1_sdo_msb", sdo4, 1);
        repeat (80) step();
        chk("t1_first_rise", first_rise[0], 9);
        chk("t1_second_rise", second_rise[0], 17);
        chk("t1_rises", rises[0], 8);
        chk("t1_hi_cycles", hi_cnt[0], 32);
        chk("t1_dv_cnt", dv_cnt[0], 1);
        chk("t1_dv_cyc", dv_cyc[0], 69);
        chk("t1_dout", dv_data[0], 8'hA5);
        chk("t1_cs_rise", cs_rise[0], 73);
        chk("t1_busy_end", busy4, 0);

        // 2: chained bytes, sdi tied high
        loop4 = 0; tie4 = 1;
        din4 = 8'h03; last4 = 0; start4 = 1;
        clr_stats();
        step();
        start4 = 0;
        wait_dv(0, 200);
        chk("t2_dv1_cyc", cyc, 69);
        chk("t2_dout1", dout4, 8'hFF);
        chk("t2_gap_busy", busy4, 0);
        chk("t2_gap_cs", cs4, 0);
        chk("t2_cs_hi1", cs_hi[0], 0);
        din4 = 8'h00; last4 = 1; start4 = 1;
        clr_stats();
        step();
        start4 = 0;
        chk("t2_busy2", busy4, 1);
        repeat (75) step();
        chk("t2_first_rise", first_rise[0], 5);
        chk("t2_dv2_cyc", dv_cyc[0], 65);
        chk("t2_dout2", dv_data[0], 8'hFF);
        chk("t2_dv2_cnt", dv_cnt[0], 1);
        chk("t2_cs_rise", cs_rise[0], 69);

        // 3: cs_release in GAP, then start+cs_release together
        loop4 = 1;
        din4 = 8'hAB; last4 = 0; start4 = 1;
        clr_stats();
        step();
        start4 = 0;
        wait_dv(0, 200);
        cs_rel4 = 1;
        clr_stats();
        step();
        cs_rel4 = 0;
        chk("t3_rel_busy", busy4, 1);
        repeat (9) step();
        chk("t3_rel_cs_rise", cs_rise[0], 5);
        chk("t3_rel_no_dv", dv_cnt[0], 0);
        chk("t3_rel_no_clk", rises[0], 0);
        din4 = 8'h3C; last4 = 0; start4 = 1;
        clr_stats();
        step();
        start4 = 0;
        wait_dv(0, 200);
        chk("t3_dout_3c", dout4, 8'h3C);
        din4 = 8'h96; last4 = 1; start4 = 1; cs_rel4 = 1;
        clr_stats();
        step();
        start4 = 0; cs_rel4 = 0;
        chk("t3_both_busy", busy4, 1);
        chk("t3_both_cs", cs4, 0);
        repeat (75) step();
        chk("t3_both_dv_cyc", dv_cyc[0], 65);
        chk("t3_both_dout", dv_data[0], 8'h96);
        chk("t3_both_cs_rise", cs_rise[0], 69);

        // 4: start while busy is ignored
        din4 = 8'hE7; last4 = 1; start4 = 1;
        clr_stats();
        step();
        start4 = 0;
        repeat (19) step();
        chk("t4_busy_mid", busy4, 1);
        din4 = 8'h11; start4 = 1;
        step();
        start4 = 0;
        repeat (60) step();
        chk("t4_dv_cnt", dv_cnt[0], 1);
        chk("t4_dv_cyc", dv_cyc[0], 69);
        chk("t4_dout", dv_data[0], 8'hE7);
        chk("t4_cs_rise", cs_rise[0], 73);

        // 5: async reset mid-SHIFT
        din4 = 8'h77; last4 = 1; start4 = 1;
        clr_stats();
        step();
        start4 = 0;
        repeat (33) step();
        chk("t5_clk_hi_pre", clk_out4, 1);
        reset = 1'b0;
        #1;
        chk("t5_rst_cs", cs4, 1);
        chk("t5_rst_clk_out", clk_out4, 0);
        chk("t5_rst_busy", busy4, 0);
        chk("t5_rst_dout", dout4, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        din4 = 8'h5A; last4 = 1; start4 = 1;
        clr_stats();
        step();
        start4 = 0;
        repeat (80) step();
        chk("t5_dv_cyc", dv_cyc[0], 69);
        chk("t5_dout", dv_data[0], 8'h5A);
        chk("t5_dv_cnt", dv_cnt[0], 1);
        chk("t5_cs_rise", cs_rise[0], 73);

        // 6: CLK_DIV=1, loopback
        din1 = 8'hC3; last1 = 1; start1 = 1;
        clr_stats();
        step();
        start1 = 0;
        repeat (25) step();
        chk("t6_first_rise", first_rise[1], 3);
        chk("t6_second_rise", second_rise[1], 5);
        chk("t6_rises", rises[1], 8);
        chk("t6_hi_cycles", hi_cnt[1], 8);
        chk("t6_dv_cyc", dv_cyc[1], 18);
        chk("t6_dout", dv_data[1], 8'hC3);
        chk("t6_cs_rise", cs_rise[1], 19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
